// File: rtl/run_ctrl.sv
// Run/enable controller: sequences a datapath through clear, idle, run, burst,
// single-step and pause, driving its synchronous clear and clock enable.
module run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int CLR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             burst_mode,
    input  logic [CNT_W-1:0] burst_len,
    output logic             en,
    output logic             rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] en_count
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_BURST = 3'd3,
        S_STEP  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CLR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [CNT_W-1:0] remaining_nxt, en_count_nxt;
    logic             done_nxt;
    logic             mode_burst, mode_burst_nxt;
    logic             ret_pause, ret_pause_nxt;   // STEP returns to PAUSE when set, else IDLE

    // Moore outputs, decoded from the state register only.
    assign rst  = (state == S_CLR);
    assign en   = (state == S_RUN) || (state == S_BURST) || (state == S_STEP);
    assign busy = en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_CLR;
            clr_cnt    <= '0;
            remaining  <= '0;
            en_count   <= '0;
            done       <= 1'b0;
            mode_burst <= 1'b0;
            ret_pause  <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            remaining  <= remaining_nxt;
            en_count   <= en_count_nxt;
            done       <= done_nxt;
            mode_burst <= mode_burst_nxt;
            ret_pause  <= ret_pause_nxt;
        end
    end

    // Command priority: clear > stop > start > step.
    always_comb begin
        state_nxt      = state;
        clr_cnt_nxt    = clr_cnt;
        remaining_nxt  = remaining;
        en_count_nxt   = en ? en_count + CNT_W'(1) : en_count;
        done_nxt       = 1'b0;
        mode_burst_nxt = mode_burst;
        ret_pause_nxt  = ret_pause;

        if (clear) begin
            state_nxt     = S_CLR;
            clr_cnt_nxt   = '0;
            remaining_nxt = '0;
            en_count_nxt  = '0;
        end else begin
            case (state)
                S_CLR: begin
                    if (clr_cnt == CLR_LAST) state_nxt = S_IDLE;
                    else                     clr_cnt_nxt = clr_cnt + CLR_W'(1);
                end
                S_IDLE: begin
                    if (stop) begin
                        state_nxt = S_IDLE;
                    end else if (start) begin
                        mode_burst_nxt = burst_mode;
                        if (!burst_mode) begin
                            state_nxt = S_RUN;
                        end else if (burst_len != '0) begin
                            remaining_nxt = burst_len;
                            state_nxt     = S_BURST;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else if (step) begin
                        ret_pause_nxt = 1'b0;
                        state_nxt     = S_STEP;
                    end
                end
                S_RUN: begin
                    if (stop) state_nxt = S_PAUSE;
                end
                S_BURST: begin
                    // The current cycle has en=1, so it is always counted off.
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = S_PAUSE;
                        done_nxt  = 1'b1;
                    end else if (stop) begin
                        state_nxt = S_PAUSE;
                    end
                end
                S_STEP: begin
                    state_nxt = ret_pause ? S_PAUSE : S_IDLE;
                end
                S_PAUSE: begin
                    if (stop) begin
                        state_nxt = S_PAUSE;
                    end else if (start) begin
                        state_nxt = (mode_burst && remaining != '0) ? S_BURST : S_RUN;
                    end else if (step) begin
                        ret_pause_nxt = 1'b1;
                        state_nxt     = S_STEP;
                    end
                end
                default: state_nxt = S_CLR;
            endcase
        end
    end

endmodule
